// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point radix-2 FFT scheduler.
package fft8_pkg;

    localparam int NPTS   = 8;
    localparam int NSTAGE = 3;
    localparam int NBF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_UNLOAD  = 2'd3
    } state_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] a);
        return {a[0], a[1], a[2]};
    endfunction

endpackage

// File: rtl/fft8_sched_if.sv
// Sample-in, bin-out and external butterfly datapath signals of fft8_sched.
interface fft8_sched_if #(parameter int W = 16);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_r;
    logic [W-1:0] in_i;

    logic [W-1:0] bf_a_r;
    logic [W-1:0] bf_a_i;
    logic [W-1:0] bf_b_r;
    logic [W-1:0] bf_b_i;
    logic [1:0]   bf_tw;
    logic [W-1:0] bf_y0_r;
    logic [W-1:0] bf_y0_i;
    logic [W-1:0] bf_y1_r;
    logic [W-1:0] bf_y1_i;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;
    logic [W-1:0] out_i;

    logic         busy;

    // Source / downstream / datapath side.
    modport master (
        output in_valid, in_r, in_i, out_ready,
        output bf_y0_r, bf_y0_i, bf_y1_r, bf_y1_i,
        input  in_ready, out_valid, out_r, out_i, busy,
        input  bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        input  bf_y0_r, bf_y0_i, bf_y1_r, bf_y1_i,
        output in_ready, out_valid, out_r, out_i, busy,
        output bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_tw
    );

endinterface

// File: rtl/fft8_addr_gen.sv
// Butterfly address and twiddle generation for stage s, butterfly b (DIT, bit-reversed input).
module fft8_addr_gen
    import fft8_pkg::*;
(
    input  logic [1:0] s,
    input  logic [1:0] b,
    output logic [2:0] top,
    output logic [2:0] bot,
    output logic [1:0] tw
);

    // h = 2^s, j = b mod h, top = (b div h)*2h + j, bot = top + h, tw = j*(4/h)
    always_comb begin
        top = 3'd0;
        bot = 3'd0;
        tw  = 2'd0;
        case (s)
            2'd0: begin
                top = {b, 1'b0};
                bot = {b, 1'b1};
                tw  = 2'd0;
            end
            2'd1: begin
                top = {b[1], 1'b0, b[0]};
                bot = {b[1], 1'b1, b[0]};
                tw  = {b[0], 1'b0};
            end
            2'd2: begin
                top = {1'b0, b};
                bot = {1'b1, b};
                tw  = b;
            end
            default: begin
                top = 3'd0;
                bot = 3'd0;
                tw  = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/fft8_sched.sv
// 8-point FFT scheduler: loads a frame bit-reversed, sequences 12 external butterflies, unloads bins.
module fft8_sched
    import fft8_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst,
    fft8_sched_if.slave  bus
);

    localparam int W = 2**N;

    state_t       state_r;
    state_t       state_s;
    logic [2:0]   cnt_r;
    logic [1:0]   stage_r;
    logic [1:0]   bfi_r;
    logic [2:0]   m_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;
    logic [W-1:0] re_r [NPTS];
    logic [W-1:0] im_r [NPTS];

    logic         accept_s;
    logic         out_hs_s;
    logic         last_bf_s;
    logic [2:0]   top_s;
    logic [2:0]   bot_s;
    logic [1:0]   tw_s;

    assign accept_s  = bus.in_valid & in_ready_r;
    assign out_hs_s  = out_valid_r & bus.out_ready;
    assign last_bf_s = (stage_r == 2'(NSTAGE - 1)) && (bfi_r == 2'(NBF - 1));

    fft8_addr_gen u_addr_gen (
        .s   (stage_r),
        .b   (bfi_r),
        .top (top_s),
        .bot (bot_s),
        .tw  (tw_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_LOAD;
                else          state_s = state_r;
            end
            ST_LOAD: begin
                if (accept_s && (cnt_r == 3'd7)) state_s = ST_COMPUTE;
                else                             state_s = state_r;
            end
            ST_COMPUTE: begin
                if (last_bf_s) state_s = ST_UNLOAD;
                else           state_s = state_r;
            end
            ST_UNLOAD: begin
                if (out_hs_s && (m_r == 3'd7)) state_s = ST_IDLE;
                else                           state_s = state_r;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE) || (state_s == ST_LOAD);
            out_valid_r <= (state_s == ST_UNLOAD);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Sample, butterfly and bin counters; each wraps back to zero at the end of its phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r   <= 3'd0;
            stage_r <= 2'd0;
            bfi_r   <= 2'd0;
            m_r     <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_LOAD: begin
                    if (accept_s) cnt_r <= cnt_r + 3'd1;
                end
                ST_COMPUTE: begin
                    bfi_r <= bfi_r + 2'd1;
                    if (bfi_r == 2'(NBF - 1)) begin
                        stage_r <= last_bf_s ? 2'd0 : stage_r + 2'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_hs_s) m_r <= m_r + 3'd1;
                end
                default: begin
                    cnt_r   <= 3'd0;
                    stage_r <= 2'd0;
                    bfi_r   <= 2'd0;
                    m_r     <= 3'd0;
                end
            endcase
        end
    end

    // Register file: bit-reversed load, in-place butterfly write-back (wrapping, no scaling).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NPTS; i++) begin
                re_r[i] <= {W{1'b0}};
                im_r[i] <= {W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_LOAD: begin
                    if (accept_s) begin
                        re_r[bitrev3(cnt_r)] <= bus.in_r;
                        im_r[bitrev3(cnt_r)] <= bus.in_i;
                    end
                end
                ST_COMPUTE: begin
                    re_r[top_s] <= bus.bf_y0_r;
                    im_r[top_s] <= bus.bf_y0_i;
                    re_r[bot_s] <= bus.bf_y1_r;
                    im_r[bot_s] <= bus.bf_y1_i;
                end
                default: begin
                end
            endcase
        end
    end

    // Butterfly operands are only driven while computing.
    always_comb begin
        bus.bf_a_r = {W{1'b0}};
        bus.bf_a_i = {W{1'b0}};
        bus.bf_b_r = {W{1'b0}};
        bus.bf_b_i = {W{1'b0}};
        bus.bf_tw  = 2'd0;
        if (state_r == ST_COMPUTE) begin
            bus.bf_a_r = re_r[top_s];
            bus.bf_a_i = im_r[top_s];
            bus.bf_b_r = re_r[bot_s];
            bus.bf_b_i = im_r[bot_s];
            bus.bf_tw  = tw_s;
        end else begin
            bus.bf_tw  = 2'd0;
        end
    end

    // Output bin mux; m only moves on a handshake so data is stable under backpressure.
    always_comb begin
        bus.out_r = {W{1'b0}};
        bus.out_i = {W{1'b0}};
        if (out_valid_r) begin
            bus.out_r = re_r[m_r];
            bus.out_i = im_r[m_r];
        end else begin
            bus.out_r = {W{1'b0}};
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_fft8_sched.sv
// Directed bench for fft8_sched with a W8^k butterfly model closing the datapath loop.
module tb_fft8_sched;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   beat_cyc = 0;

    int frame_r [8];
    int frame_i [8];
    int exp_r [8];
    int exp_i [8];

    fft8_sched_if #(.W(16)) bus ();

    fft8_sched #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int mul_c(input int x);
        return (x * 23170 + 16384) >>> 15;
    endfunction

    // Butterfly datapath: y0 = a + b*W8^k, y1 = a - b*W8^k, W8 = exp(-j*2*pi/8).
    int a_r, a_i, b_r, b_i, p_r, p_i;
    always_comb begin
        a_r = $signed(bus.bf_a_r);
        a_i = $signed(bus.bf_a_i);
        b_r = $signed(bus.bf_b_r);
        b_i = $signed(bus.bf_b_i);
        p_r = b_r;
        p_i = b_i;
        case (bus.bf_tw)
            2'd0: begin p_r = b_r;               p_i = b_i;               end
            2'd1: begin p_r = mul_c(b_r + b_i);  p_i = mul_c(b_i - b_r);  end
            2'd2: begin p_r = b_i;               p_i = -b_r;              end
            default: begin p_r = mul_c(b_i - b_r); p_i = mul_c(-(b_r + b_i)); end
        endcase
        bus.bf_y0_r = 16'(a_r + p_r);
        bus.bf_y0_i = 16'(a_i + p_i);
        bus.bf_y1_r = 16'(a_r - p_r);
        bus.bf_y1_i = 16'(a_i - p_i);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_impulse();
        for (int i = 0; i < 8; i++) begin
            frame_r[i] = (i == 0) ? 1 : 0;
            frame_i[i] = 0;
            exp_r[i]   = 1;
            exp_i[i]   = 0;
        end
    endtask

    task automatic set_dc();
        for (int i = 0; i < 8; i++) begin
            frame_r[i] = 1;
            frame_i[i] = 0;
            exp_r[i]   = (i == 0) ? 8 : 0;
            exp_i[i]   = 0;
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the edge that takes the last sample.
    task automatic send_frame(input bit throttle, input bit hold_after);
        int k;
        int t;
        k = 0;
        t = 0;
        while (k < 8 && t < 100) begin
            bus.in_valid = !throttle || (t % 2 == 0);
            bus.in_r     = 16'(frame_r[k]);
            bus.in_i     = 16'(frame_i[k]);
            if (bus.in_valid && bus.in_ready) begin
                beat_cyc = cyc;
                k++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        chk("beats_sent", k, 8);
        bus.in_valid = hold_after;
        bus.in_r     = 16'h5A5A;
        bus.in_i     = 16'h0123;
    endtask

    task automatic recv_frame(input bit stall);
        int m;
        int t;
        int p;
        bit held;
        bit first;
        int hr;
        int hi;
        m = 0; t = 0; p = 0; held = 1'b0; first = 1'b1; hr = 0; hi = 0;
        while (m < 8 && t < 400) begin
            if (!bus.out_valid && bus.in_valid) chk("in_ready_compute", int'(bus.in_ready), 0);
            bus.out_ready = !stall || (p % 4 == 0);
            if (bus.out_valid) begin
                if (first) begin
                    chk("latency", cyc - beat_cyc, 13);
                    first = 1'b0;
                    bus.in_valid = 1'b0;
                end
                if (held) begin
                    chk("stall_hold_r", $signed(bus.out_r), hr);
                    chk("stall_hold_i", $signed(bus.out_i), hi);
                end
                if (bus.out_ready) begin
                    chk($sformatf("bin%0d_r", m), $signed(bus.out_r), exp_r[m]);
                    chk($sformatf("bin%0d_i", m), $signed(bus.out_i), exp_i[m]);
                    m++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hr = $signed(bus.out_r);
                    hi = $signed(bus.out_i);
                end
                p++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        chk("bins_received", m, 8);
        bus.out_ready = 1'b0;
        chk("post_in_ready", int'(bus.in_ready), 1);
        chk("post_out_valid", int'(bus.out_valid), 0);
        chk("post_busy", int'(bus.busy), 0);
        chk("post_bf_tw", int'(bus.bf_tw), 0);
    endtask

    initial begin
        bit seen;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_r      = 16'h0000;
        bus.in_i      = 16'h0000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_bf_tw", int'(bus.bf_tw), 0);
        chk("rst_bf_a_r", int'(bus.bf_a_r), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", int'(bus.in_ready), 1);
        chk("rel_busy", int'(bus.busy), 0);

        set_impulse();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0);

        // Back-to-back: starts on the cycle after the bin-7 handshake.
        set_dc();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0);

        set_dc();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b1);

        set_dc();
        send_frame(1'b1, 1'b1);
        recv_frame(1'b0);

        // Reset in the 5th compute cycle discards the frame.
        set_impulse();
        send_frame(1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", int'(bus.busy), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_out_valid", int'(bus.out_valid), 0);
        chk("mrst_in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rel_in_ready", int'(bus.in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mrst_no_output", int'(seen), 0);
        bus.out_ready = 1'b0;

        set_impulse();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
